// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver. Two-flop synchronizes the serial line, detects
//               the start bit, samples start/data/stop at mid-bit
//               (data LSB-first) and hands each byte out on valid/ready.
//               A bad stop bit pulses frame_err; a good frame arriving while
//               the previous byte is still pending pulses overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int HALF        = PULSE_WIDTH / 2;
  localparam int CW          = $clog2(PULSE_WIDTH);
  localparam int IW          = $clog2(DATA_WIDTH) + 1;

  localparam logic [CW-1:0] C_HALF_LAST  = CW'(HALF - 1);
  localparam logic [CW-1:0] C_PULSE_LAST = CW'(PULSE_WIDTH - 1);
  localparam logic [IW-1:0] C_BIT_LAST   = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic                  sync_1;
  logic                  line;
  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;

  // Two-flop synchronizer; both stages reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b1;
      line   <= 1'b1;
    end else begin
      sync_1 <= rx_sig;
      line   <= sync_1;
    end
  end

  // Frame FSM with bit timer, shift register and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Consumer took the byte this cycle; a commit below may re-set valid.
      if (valid && ready) valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!line) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == C_HALF_LAST) begin
            cnt <= '0;
            if (line) begin
              // Line went back high before mid-start: treat as a glitch.
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == C_PULSE_LAST) begin
            cnt   <= '0;
            shreg <= {line, shreg[DATA_WIDTH-1:1]};
            if (bit_idx == C_BIT_LAST) state <= S_STOP;
            else                       bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == C_PULSE_LAST) begin
            cnt <= '0;
            if (line) begin
              // Leave at mid-stop so a directly following start is caught.
              state <= S_IDLE;
              if (!valid || ready) begin
                data  <= shreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BREAK: begin
          // Hold off start detection until the line has returned high.
          if (line) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx. A frame-level model decodes
//               the driven line using bit-time arithmetic and is compared
//               against the DUT every cycle; directed tests add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int W    = 8;
  localparam int BAUD = 100_000;
  localparam int CLKF = 1_600_000;
  localparam int P    = CLKF / BAUD;   // 16 clocks per bit
  localparam int HALF = P / 2;         // 8

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_sig = 1'b1;
  logic         ready = 1'b1;
  logic [W-1:0] data;
  logic         valid;
  logic         frame_err;
  logic         overrun;

  uart_rx #(.DATA_WIDTH(W), .BAUD_RATE(BAUD), .CLK_FREQ(CLKF)) dut (
    .clk(clk), .rst(rst), .rx_sig(rx_sig), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  int           ecount  = 0;   // posedges elapsed
  bit           started = 0;
  bit           ml1 = 1, ml2 = 1, ln;
  int           mode = 0;      // 0 idle, 1 in frame, 2 waiting for line high
  int           t0, d, k;
  logic [W-1:0] mbyte;
  logic         m_valid = 0, m_fe = 0, m_ov = 0, vprev;
  logic [W-1:0] m_data = '0;

  // Model advances at each posedge on the same inputs the DUT samples.
  always @(posedge clk) begin
    ecount++;
    started = 1;
    if (rst) begin
      ml1 = 1; ml2 = 1; mode = 0;
      m_valid = 0; m_data = '0; m_fe = 0; m_ov = 0;
    end else begin
      ln  = ml2;               // line as seen this edge: rx from two edges ago
      ml2 = ml1;
      ml1 = rx_sig;
      m_fe = 0; m_ov = 0;
      vprev = m_valid;
      if (m_valid && ready) m_valid = 0;
      if (mode == 0) begin
        if (!ln) begin t0 = ecount; mode = 1; end
      end else if (mode == 1) begin
        d = ecount - t0;
        if (d == HALF) begin
          if (ln) mode = 0;
        end else if (d > HALF && (d - HALF) % P == 0) begin
          k = (d - HALF) / P - 1;
          if (k < W) mbyte[k] = ln;
          else if (ln) begin
            mode = 0;
            if (!vprev || ready) begin m_data = mbyte; m_valid = 1; end
            else m_ov = 1;
          end else begin
            m_fe = 1; mode = 2;
          end
        end
      end else begin
        if (ln) mode = 0;
      end
    end
  end

  // ---------------- per-cycle compare and observation ----------------
  logic [W-1:0] got[$];
  int fe_cnt = 0, ov_cnt = 0;
  int vrise_edge = 0, vlen = 0;
  logic vlast = 0;

  always @(negedge clk) begin
    if (started) begin
      check("valid", valid, m_valid);
      check("data", data, m_data);
      check("frame_err", frame_err, m_fe);
      check("overrun", overrun, m_ov);
      fe_cnt += int'(frame_err);
      ov_cnt += int'(overrun);
      if (valid && !vlast) begin vrise_edge = ecount; vlen = 0; end
      if (valid) vlen++;
      vlast = valid;
      if (valid && ready && !rst) got.push_back(data);
    end
  end

  // ---------------- stimulus helpers ----------------
  int fall_edge = 0;

  task automatic hold(input logic v, input int cycles);
    rx_sig = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] b, input logic stop);
    fall_edge = ecount + 1;
    hold(1'b0, P);
    for (int i = 0; i < W; i++) hold(b[i], P);
    hold(stop, P);
  endtask

  task automatic check_got(input string name, input int n, input logic [W-1:0] b0);
    check({name, "_count"}, got.size(), n);
    if (got.size() > 0) check({name, "_byte"}, got[0], b0);
    got.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [W-1:0] pb;
    int           fe0, ov0;

    // Reset
    repeat (100) @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_fe", frame_err, 0);
    check("rst_ov", overrun, 0);
    rst = 1'b0;
    hold(1'b1, 20 * P);
    check_got("idle", 0, 8'h00);
    check("idle_fe", fe_cnt, 0);

    // Single frame: valid appears 2 sync + HALF + 9 bit times after the fall
    send(8'hA5, 1'b1);
    hold(1'b1, 2 * P);
    check("single_latency", vrise_edge - fall_edge, 154);
    check("single_width", vlen, 1);
    check_got("single", 1, 8'hA5);

    // Glitch shorter than half a bit
    hold(1'b0, HALF / 2 + 1);
    hold(1'b1, 2 * P);
    check_got("glitch", 0, 8'h00);
    check("glitch_fe", fe_cnt, 0);
    send(8'h3C, 1'b1);
    hold(1'b1, P);
    check_got("after_glitch", 1, 8'h3C);

    // Framing error followed by a held-low break
    send(8'h55, 1'b0);
    hold(1'b0, 3 * P);
    hold(1'b1, 2 * P);
    check("ferr_count", fe_cnt, 1);
    check("ferr_valid", valid, 0);
    check_got("ferr", 0, 8'h00);
    send(8'h0F, 1'b1);
    hold(1'b1, P);
    check_got("after_ferr", 1, 8'h0F);

    // Overrun: second byte dropped while first is pending
    ready = 1'b0;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    hold(1'b1, P);
    check("ovr_data", data, 8'h11);
    check("ovr_valid", valid, 1);
    check("ovr_count", ov_cnt, 1);
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_consumed", valid, 0);
    check_got("ovr", 1, 8'h11);

    // Back-to-back sweep of all byte values
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 256; i++) send(W'(i), 1'b1);
    hold(1'b1, P);
    check("sweep_count", got.size(), 256);
    for (int i = 0; i < 256 && i < got.size(); i++) check("sweep_byte", got[i], i);
    got.delete();
    check("sweep_fe", fe_cnt - fe0, 0);
    check("sweep_ov", ov_cnt - ov0, 0);

    // Reset during bit 4 of a frame discards everything
    ready = 1'b0;
    send(8'hC3, 1'b1);
    hold(1'b1, P);
    check("pre_rst_valid", valid, 1);
    pb = 8'h99;
    hold(1'b0, P);
    for (int i = 0; i < 4; i++) hold(pb[i], P);
    hold(pb[4], HALF);
    rst = 1'b1;
    rx_sig = 1'b1;
    @(negedge clk);
    check("midrst_valid", valid, 0);
    check("midrst_data", data, 0);
    rst = 1'b0;
    hold(1'b1, 2 * P);
    ready = 1'b1;
    send(8'h6B, 1'b1);
    hold(1'b1, P);
    check_got("after_rst", 1, 8'h6B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
